// File: rtl/sync_debouncer.sv
// Debouncer for an asynchronous, bouncy single-bit input: a flop synchronizer followed by
// a stability-counting FSM. It also keeps a saturating count of rejected glitches.
module sync_debouncer #(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 4,
    parameter logic RESET_VALUE   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din_raw,
    output logic       din_clean,
    output logic       busy,
    output logic [7:0] glitch_cnt
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_CHECKING = 1'b1
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;

    // Plain shift chain: no logic between the synchronizer flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din_raw};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    // busy is registered together with the state, so it never depends combinationally on din_raw.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_STABLE;
            cnt        <= '0;
            busy       <= 1'b0;
            din_clean  <= RESET_VALUE;
            glitch_cnt <= 8'd0;
        end else begin
            case (state)
                ST_STABLE: begin
                    if (s != din_clean) begin
                        state <= ST_CHECKING;
                        cnt   <= CW'(1);
                        busy  <= 1'b1;
                    end else begin
                        cnt  <= '0;
                        busy <= 1'b0;
                    end
                end
                ST_CHECKING: begin
                    if (s == din_clean) begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        if (glitch_cnt != 8'hFF) begin
                            glitch_cnt <= glitch_cnt + 8'd1;
                        end
                    end else if (cnt == CNT_LAST) begin
                        din_clean <= s;
                        state     <= ST_STABLE;
                        cnt       <= '0;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule
